// File: rtl/fade_pkg.sv
// Shared types and helpers for the hsv_fade_n LED fade controller.
package fade_pkg;

  typedef enum logic [1:0] {
    MODE_HSV     = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_STATIC  = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  localparam int NUM_SEG = 6;

  // Brightness level for a channel in local segment ls: rise, hold high (two segments), fall, hold low.
  function automatic int unsigned seg_level(input int unsigned ls,
                                            input int unsigned step,
                                            input int unsigned steps);
    case (ls)
      0:       seg_level = step;
      1, 2:    seg_level = steps;
      3:       seg_level = steps - step;
      default: seg_level = 0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_ch.sv
// One PWM output channel: duty register, compare against the shared counter, polarity output register.
// Define HSV_FADE_SYNC_EN to defer duty changes to the start of the next PWM period.
module pwm_ch #(
  parameter int DW           = 4,
  parameter int PWM_INTERVAL = 8,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] duty_in,
  output logic          led
);

  logic [DW-1:0] duty_reg;
  logic [DW-1:0] eff_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_reg <= '0;
    else     duty_reg <= duty_in;
  end

`ifdef HSV_FADE_SYNC_EN
  logic [DW-1:0] eff_reg;

  // Latch on the last count of a period so the new duty starts cleanly at cnt=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  eff_reg <= '0;
    else if (cnt == DW'(PWM_INTERVAL - 1))    eff_reg <= duty_reg;
  end

  assign eff_duty = eff_reg;
`else
  assign eff_duty = duty_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= ACTIVE_LOW;
    else     led <= (cnt < eff_duty) ^ ACTIVE_LOW;
  end

endmodule

// File: rtl/hsv_fade_n.sv
// N-channel fade controller: step sequencer (HSV / breathe / static / off) feeding a shared-counter PWM bank.
// Optional HSV_FADE_SYNC_EN makes each channel apply new duties only at PWM period boundaries.
module hsv_fade_n
  import fade_pkg::*;
#(
  parameter int N_CH          = 3,
  parameter int PWM_INTERVAL  = 1200,
  parameter int STEPS         = 200,
  parameter int STEP_INTERVAL = 10000,
  parameter bit ACTIVE_LOW    = 1'b1,
  localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [N_CH*DW-1:0] static_duty,
  output logic [N_CH-1:0]    led_out,
  output logic [2:0]         seg,
  output logic               step_tick
);

  localparam int PSW   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int RATIO = PWM_INTERVAL / STEPS;

  mode_t          mode_in;
  mode_t          mode_reg;
  logic [PSW-1:0] presc_reg;
  logic [SW-1:0]  step_reg;
  logic [2:0]     seg_reg;
  logic [2:0]     seg_next;
  logic           tick_reg;
  logic [DW-1:0]  cnt_reg;

  assign mode_in = mode_t'(mode);

  always_comb begin
    seg_next = 3'd0;
    case (mode_reg)
      MODE_HSV:     seg_next = (seg_reg == 3'(NUM_SEG - 1)) ? 3'd0 : seg_reg + 3'd1;
      MODE_BREATHE: seg_next = (seg_reg == 3'd0) ? 3'd1 : 3'd0;
      default:      seg_next = 3'd0;
    endcase
  end

  // A mode change takes priority over any step wrap on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= MODE_HSV;
      presc_reg <= '0;
      step_reg  <= '0;
      seg_reg   <= '0;
      tick_reg  <= 1'b0;
    end else begin
      mode_reg <= mode_in;
      tick_reg <= 1'b0;
      if (mode_in != mode_reg) begin
        presc_reg <= '0;
        step_reg  <= '0;
        seg_reg   <= '0;
      end else if (en) begin
        if (presc_reg == PSW'(STEP_INTERVAL - 1)) begin
          presc_reg <= '0;
          tick_reg  <= 1'b1;
          if (step_reg == SW'(STEPS - 1)) begin
            step_reg <= '0;
            seg_reg  <= seg_next;
          end else begin
            step_reg <= step_reg + SW'(1);
          end
        end else begin
          presc_reg <= presc_reg + PSW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cnt_reg <= '0;
    else if (cnt_reg == DW'(PWM_INTERVAL - 1)) cnt_reg <= '0;
    else                                       cnt_reg <= cnt_reg + DW'(1);
  end

  assign seg       = seg_reg;
  assign step_tick = tick_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // Channels are spread two segments apart around the hue wheel.
    localparam int OFS = (2 * gi) % NUM_SEG;

    logic [2:0]    ls;
    logic [DW-1:0] static_clamped;
    logic [DW-1:0] duty_next;

    assign ls = 3'((32'(seg_reg) + NUM_SEG - OFS) % NUM_SEG);
    assign static_clamped = (static_duty[gi*DW +: DW] > DW'(PWM_INTERVAL)) ?
                            DW'(PWM_INTERVAL) : static_duty[gi*DW +: DW];

    always_comb begin
      duty_next = '0;
      case (mode_reg)
        MODE_HSV:
          duty_next = DW'(seg_level(32'(ls), 32'(step_reg), STEPS) * RATIO);
        MODE_BREATHE:
          duty_next = DW'(seg_level((seg_reg == 3'd0) ? 32'd0 : 32'd3, 32'(step_reg), STEPS) * RATIO);
        MODE_STATIC:
          duty_next = static_clamped;
        default:
          duty_next = '0;
      endcase
    end

    pwm_ch #(
      .DW           (DW),
      .PWM_INTERVAL (PWM_INTERVAL),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt_reg),
      .duty_in (duty_next),
      .led     (led_out[gi])
    );
  end

endmodule
